// File: rtl/motor_clk_pkg.sv
// Shared constants and helpers for the motor tick generator.
package motor_clk_pkg;

    // Default divisor / counter width
    localparam int CNT_W_DEF    = 16;

    // Divisor value that silences a channel
    localparam int DIV_DISABLED = 0;

    // Channel-index width: clog2 with a floor of one bit
    function automatic int ch_idx_w(input int num_ch);
        if (num_ch <= 1) begin
            return 1;
        end else begin
            return $clog2(num_ch);
        end
    endfunction

endpackage

// File: rtl/motor_tick_ch.sv
// One tick-generator channel: counter, active/shadow divisor, pending flag,
// registered tick and square-wave outputs.
// Optional MOTOR_TICK_COUNT_EN adds an 8-bit count of issued ticks.
module motor_tick_ch
    import motor_clk_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = 16384
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_val,
    output logic             pend,
    output logic             tick,
    output logic             clk_out
`ifdef MOTOR_TICK_COUNT_EN
    ,
    output logic [7:0]       tick_cnt
`endif
);

    localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] DIS_C     = CNT_W'(DIV_DISABLED);

    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [CNT_W-1:0] div_r, div_s;
    logic [CNT_W-1:0] shadow_r, shadow_s;
    logic             pend_r, pend_s;
    logic             tick_r, tick_s;
    logic             clk_out_r, clk_out_s;
    logic             apply_s;
    logic             wrap_s;

    // Next-state: counter advance, wrap detect, divisor apply and shadow capture
    always_comb begin
        cnt_s     = cnt_r;
        apply_s   = 1'b0;
        wrap_s    = 1'b0;
        if (sync) begin
            cnt_s   = '0;
            apply_s = pend_r;
        end else if (en) begin
            if (div_r == DIS_C) begin
                // Silent channel picks up a pending divisor on any enabled edge
                cnt_s   = '0;
                apply_s = pend_r;
            end else if (cnt_r >= (div_r - CNT_W'(1))) begin
                cnt_s   = '0;
                wrap_s  = 1'b1;
                apply_s = pend_r;
            end else begin
                cnt_s   = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_s = cnt_r;
        end

        if (apply_s) begin
            div_s = shadow_r;
        end else begin
            div_s = div_r;
        end

        tick_s = wrap_s;

        // Square wave follows the counter value it will hold after this edge
        if (sync || en) begin
            clk_out_s = (cnt_s < (div_s >> 1));
        end else begin
            clk_out_s = clk_out_r;
        end

        // A write lands after any apply, so it always stays pending
        if (wr) begin
            shadow_s = wr_val;
            pend_s   = 1'b1;
        end else if (apply_s) begin
            shadow_s = shadow_r;
            pend_s   = 1'b0;
        end else begin
            shadow_s = shadow_r;
            pend_s   = pend_r;
        end
    end

    // Channel state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_r     <= '0;
            div_r     <= DEF_DIV_C;
            shadow_r  <= DEF_DIV_C;
            pend_r    <= 1'b0;
            tick_r    <= 1'b0;
            clk_out_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_s;
            div_r     <= div_s;
            shadow_r  <= shadow_s;
            pend_r    <= pend_s;
            tick_r    <= tick_s;
            clk_out_r <= clk_out_s;
        end
    end

    assign pend    = pend_r;
    assign tick    = tick_r;
    assign clk_out = clk_out_r;

`ifdef MOTOR_TICK_COUNT_EN
    logic [7:0] tick_cnt_r;

    // Free-running count of issued ticks, cleared by reset and sync
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            tick_cnt_r <= 8'd0;
        end else if (sync) begin
            tick_cnt_r <= 8'd0;
        end else if (wrap_s) begin
            tick_cnt_r <= tick_cnt_r + 8'd1;
        end else begin
            tick_cnt_r <= tick_cnt_r;
        end
    end

    assign tick_cnt = tick_cnt_r;
`endif

endmodule

// File: rtl/motor_tick_gen.sv
// Multi-channel programmable clock-enable / square-wave generator.
// Top level decodes divisor writes and fans out sync to every channel.
// Define MOTOR_TICK_COUNT_EN to add the per-channel tick_cnt output.
module motor_tick_gen
    import motor_clk_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = 16384
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          en,
    input  logic                          sync,
    input  logic                          div_wr,
    input  logic [ch_idx_w(NUM_CH)-1:0]   div_ch,
    input  logic [CNT_W-1:0]              div_val,
    output logic [NUM_CH-1:0]             div_pend,
    output logic [NUM_CH-1:0]             tick,
    output logic [NUM_CH-1:0]             clk_out
`ifdef MOTOR_TICK_COUNT_EN
    ,
    output logic [NUM_CH*8-1:0]           tick_cnt
`endif
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] wr_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        // Out-of-range channel indices never match, so those writes vanish
        assign wr_s[g] = div_wr && (div_ch == CH_W'(g));

        motor_tick_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk      (clk),
            .n_rst    (n_rst),
            .en       (en),
            .sync     (sync),
            .wr       (wr_s[g]),
            .wr_val   (div_val),
            .pend     (div_pend[g]),
            .tick     (tick[g]),
            .clk_out  (clk_out[g])
`ifdef MOTOR_TICK_COUNT_EN
            ,
            .tick_cnt (tick_cnt[g*8 +: 8])
`endif
        );
    end

endmodule

// File: tb/tb_motor_tick_gen.sv
// Self-checking bench for motor_tick_gen (DEF_DIV overridden to 8).
module tb_motor_tick_gen;

    localparam int NCH  = 4;
    localparam int CW   = 16;
    localparam int DDIV = 8;

    logic           clk = 1'b0;
    logic           n_rst;
    logic           en;
    logic           sync;
    logic           div_wr;
    logic [1:0]     div_ch;
    logic [CW-1:0]  div_val;
    logic [NCH-1:0] div_pend;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] clk_out;
`ifdef MOTOR_TICK_COUNT_EN
    logic [NCH*8-1:0] tick_cnt;
`endif

    always #5 clk = ~clk;

    motor_tick_gen #(
        .NUM_CH  (NCH),
        .CNT_W   (CW),
        .DEF_DIV (DDIV)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .en       (en),
        .sync     (sync),
        .div_wr   (div_wr),
        .div_ch   (div_ch),
        .div_val  (div_val),
        .div_pend (div_pend),
        .tick     (tick),
        .clk_out  (clk_out)
`ifdef MOTOR_TICK_COUNT_EN
        ,
        .tick_cnt (tick_cnt)
`endif
    );

    typedef struct {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] clk_out;
        logic [NCH-1:0] pend;
        logic [31:0]    tc;
    } exp_t;

    typedef struct {
        bit en;
        bit sy;
        bit wr;
        int ch;
        int val;
        bit x_tick;
        bit x_clk;
        bit x_pend;
    } vec_t;

    exp_t sb_q[$];

    int m_cnt[NCH];
    int m_div[NCH];
    int m_sh[NCH];
    int m_pend[NCH];
    int m_tc[NCH];
    logic [NCH-1:0] m_tick;
    logic [NCH-1:0] m_clk;

    int n_vec = 0;
    int n_err = 0;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_div[c] = DDIV; m_sh[c] = DDIV; m_pend[c] = 0; m_tc[c] = 0;
        end
        m_tick = '0;
        m_clk  = '0;
    endfunction

    function automatic void model_step(input bit e, input bit s, input bit w, input int ch, input int v);
        for (int c = 0; c < NCH; c++) begin
            if (s) begin
                if (m_pend[c] != 0) m_div[c] = m_sh[c];
                m_pend[c] = 0;
                m_cnt[c]  = 0;
                m_tick[c] = 1'b0;
                m_tc[c]   = 0;
                m_clk[c]  = (m_div[c] >= 2);
            end else if (e) begin
                if (m_div[c] == 0) begin
                    m_tick[c] = 1'b0;
                    m_cnt[c]  = 0;
                    if (m_pend[c] != 0) begin m_div[c] = m_sh[c]; m_pend[c] = 0; end
                end else if (m_cnt[c] + 1 == m_div[c]) begin
                    m_tick[c] = 1'b1;
                    m_cnt[c]  = 0;
                    m_tc[c]   = (m_tc[c] + 1) % 256;
                    if (m_pend[c] != 0) begin m_div[c] = m_sh[c]; m_pend[c] = 0; end
                end else begin
                    m_tick[c] = 1'b0;
                    m_cnt[c]  = m_cnt[c] + 1;
                end
                m_clk[c] = (m_cnt[c] < m_div[c] / 2);
            end else begin
                m_tick[c] = 1'b0;
            end
            if (w && ch == c) begin
                m_sh[c]   = v;
                m_pend[c] = 1;
            end
        end
    endfunction

    function automatic exp_t model_snap();
        exp_t x;
        x.tick    = m_tick;
        x.clk_out = m_clk;
        for (int c = 0; c < NCH; c++) x.pend[c] = (m_pend[c] != 0);
        x.tc = {8'(m_tc[3]), 8'(m_tc[2]), 8'(m_tc[1]), 8'(m_tc[0])};
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_check();
        exp_t x;
        logic [31:0] tc_act;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: queue empty at t=%0t", $time);
        end else begin
            x = sb_q.pop_front();
`ifdef MOTOR_TICK_COUNT_EN
            tc_act = tick_cnt;
`else
            tc_act = x.tc;
`endif
            if (tick !== x.tick || clk_out !== x.clk_out || div_pend !== x.pend || tc_act !== x.tc) begin
                n_err++;
                $display("FAIL scoreboard t=%0t: tick %h/%h clk_out %h/%h div_pend %h/%h tick_cnt %h/%h (got/exp)",
                         $time, tick, x.tick, clk_out, x.clk_out, div_pend, x.pend, tc_act, x.tc);
            end
        end
    endtask

    task automatic step(input bit e, input bit s, input bit w, input int c, input int v);
        en      = e;
        sync    = s;
        div_wr  = w;
        div_ch  = 2'(c);
        div_val = CW'(v);
        model_step(e, s, w, c, v);
        sb_q.push_back(model_snap());
        @(posedge clk);
        #1;
        sb_check();
        sync   = 1'b0;
        div_wr = 1'b0;
    endtask

    task automatic rst_step();
        n_rst  = 1'b0;
        en     = 1'b0;
        sync   = 1'b0;
        div_wr = 1'b0;
        model_reset();
        sb_q.push_back(model_snap());
        @(posedge clk);
        #1;
        sb_check();
        n_rst = 1'b1;
    endtask

    // Step with en=1 until tick[ch] is seen; n returns edges taken
    task automatic run_until_tick(input int ch, input int max_n, output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < max_n) begin
            step(1'b1, 1'b0, 1'b0, 0, 0);
            n++;
            if (tick[ch]) seen = 1'b1;
        end
        if (!seen) begin
            n_err++;
            $display("FAIL tick_timeout ch%0d: no tick within %0d edges", ch, max_n);
        end
    endtask

    vec_t tbl[10];
    int   n;
    int   cnt_t;
    int   first[NCH];
    logic [NCH-1:0] saved_clk;

    initial begin
        n_rst = 1'b0; en = 1'b0; sync = 1'b0; div_wr = 1'b0; div_ch = 2'd0; div_val = '0;

        // ch0 after reset, N=8; rewrite of the active value at edge 3
        tbl[0] = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 0, 8, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0};

        rst_step();
        rst_step();
        chk("rst_tick", int'(tick), 0);
        chk("rst_clk_out", int'(clk_out), 0);
        chk("rst_div_pend", int'(div_pend), 0);

        // Table vectors: edges 1..10 after reset
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].en, tbl[i].sy, tbl[i].wr, tbl[i].ch, tbl[i].val);
            chk($sformatf("tbl%0d_tick0", i), int'(tick[0]), int'(tbl[i].x_tick));
            chk($sformatf("tbl%0d_clk0", i), int'(clk_out[0]), int'(tbl[i].x_clk));
            chk($sformatf("tbl%0d_pend0", i), int'(div_pend[0]), int'(tbl[i].x_pend));
        end

        // Edges 11..24: ticks at 16 and 24
        cnt_t = 0;
        for (int i = 11; i <= 24; i++) begin
            step(1'b1, 1'b0, 1'b0, 0, 0);
            if (tick[0]) cnt_t++;
            if (i == 16) chk("tick_edge16", int'(tick[0]), 1);
        end
        chk("ticks_11_24", cnt_t, 2);
        chk("tick_edge24", int'(tick[0]), 1);

        // ch1 N=5 written at cnt=2 of an N=8 period
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b1, 1, 5);
        chk("ch1_pend_set", int'(div_pend[1]), 1);
        run_until_tick(1, 20, n);
        chk("ch1_finish_old_period", n, 5);
        chk("ch1_pend_clear", int'(div_pend[1]), 0);
        run_until_tick(1, 20, n);
        chk("ch1_new_period", n, 5);

        // ch2 N=0 silences the channel, then N=3 applies one edge after its write
        step(1'b1, 1'b0, 1'b1, 2, 0);
        run_until_tick(2, 20, n);
        chk("ch2_pend_after_zero", int'(div_pend[2]), 0);
        cnt_t = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0, 0, 0);
            if (tick[2]) cnt_t++;
        end
        chk("ch2_silent_ticks", cnt_t, 0);
        chk("ch2_silent_clk", int'(clk_out[2]), 0);
        step(1'b1, 1'b0, 1'b1, 2, 3);
        chk("ch2_n3_pend", int'(div_pend[2]), 1);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        chk("ch2_n3_applied", int'(div_pend[2]), 0);
        run_until_tick(2, 20, n);
        chk("ch2_n3_first_tick", n, 3);

        // N=4/6/7 then sync mid-period with a concurrent write on ch0
        step(1'b1, 1'b0, 1'b1, 0, 4);
        step(1'b1, 1'b0, 1'b1, 1, 6);
        step(1'b1, 1'b0, 1'b1, 2, 7);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b1, 1'b1, 0, 4);
        chk("sync_pend", int'(div_pend), 1);
        chk("sync_tick", int'(tick), 0);
        for (int c = 0; c < NCH; c++) first[c] = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 1'b0, 0, 0);
            for (int c = 0; c < NCH; c++) if (tick[c] && first[c] == 0) first[c] = i;
        end
        chk("sync_first_ch0", first[0], 4);
        chk("sync_first_ch1", first[1], 6);
        chk("sync_first_ch2", first[2], 7);
        chk("sync_first_ch3", first[3], 8);

        // en low for 10 cycles at ch3 cnt=3 (N=8); sync with en low still restarts
        step(1'b0, 1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        saved_clk = clk_out;
        cnt_t = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, (i == 0), 0, 9);
            if (tick != '0) cnt_t++;
        end
        chk("en_low_ticks", cnt_t, 0);
        chk("en_low_clk_frozen", int'(clk_out), int'(saved_clk));
        chk("en_low_write_pend", int'(div_pend[0]), 1);
        run_until_tick(3, 20, n);
        chk("en_resume_tick", n, 5);

        // N=1 on ch0 for 260 cycles
        step(1'b1, 1'b0, 1'b1, 0, 1);
        step(1'b1, 1'b1, 1'b0, 0, 0);
        cnt_t = 0;
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 1'b0, 1'b0, 0, 0);
            if (tick[0]) cnt_t++;
        end
        chk("n1_ticks", cnt_t, 260);
        chk("n1_clk_out", int'(clk_out[0]), 0);
`ifdef MOTOR_TICK_COUNT_EN
        chk("tick_cnt_wrap", int'(tick_cnt[7:0]), 4);
`endif
        step(1'b1, 1'b1, 1'b0, 0, 0);
`ifdef MOTOR_TICK_COUNT_EN
        chk("tick_cnt_sync_clear", int'(tick_cnt[7:0]), 0);
`endif

        // Reset mid-period discards a pending write
        step(1'b1, 1'b0, 1'b1, 1, 9);
        chk("pre_rst_pend", int'(div_pend[1]), 1);
        rst_step();
        chk("mid_rst_pend", int'(div_pend), 0);
        run_until_tick(1, 20, n);
        chk("post_rst_period", n, DDIV);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
